// File: rtl/rvv_vd_writeback_pkg.sv
// Shared definitions for the vector destination writeback block: FSM state codes,
// SEW encodings and the per-SEW byte-enable pattern of a single element.
package rvv_vd_writeback_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;

    localparam logic [2:0] SEW_8  = 3'd0;
    localparam logic [2:0] SEW_16 = 3'd1;
    localparam logic [2:0] SEW_32 = 3'd2;
    localparam logic [2:0] SEW_64 = 3'd3;

    // Byte-enable pattern of one element at byte offset zero.
    function automatic logic [7:0] elem_be(input logic [2:0] vsew);
        case (vsew)
            SEW_8:   elem_be = 8'h01;
            SEW_16:  elem_be = 8'h03;
            SEW_32:  elem_be = 8'h0F;
            default: elem_be = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/rvv_elem_insert.sv
// Places one lane's element into a VLEN-wide image with matching byte enables;
// dropped writes (tail, out of range, masked off, not valid) yield all-zero enables.
module rvv_elem_insert
    import rvv_vd_writeback_pkg::*;
#(
    parameter int VLEN = 128
) (
    input  logic [2:0]        vsew,
    input  logic [9:0]        idx,
    input  logic [10:0]       vl,
    input  logic              mask_en,
    input  logic [VLEN-1:0]   v0,
    input  logic [63:0]       vd,
    input  logic              vld,
    output logic [VLEN-1:0]   data,
    output logic [VLEN/8-1:0] be
);

    localparam int NBYTES = VLEN / 8;

    logic [16:0] off;
    logic [63:0] elem;
    logic        mask_bit;
    logic        keep;

    always_comb begin
        off = {7'b0, idx} << ({1'b0, vsew[1:0]} + 3'd3);

        // Indices beyond VLEN read as mask-off rather than indexing past v0.
        mask_bit = 1'b0;
        for (int i = 0; i < VLEN; i++) begin
            if (idx == 10'(i)) mask_bit = v0[i];
        end

        keep = vld && ({1'b0, idx} < vl) && (off < 17'(VLEN)) && (!mask_en || mask_bit);

        case (vsew)
            SEW_8:   elem = {56'b0, vd[7:0]};
            SEW_16:  elem = {48'b0, vd[15:0]};
            SEW_32:  elem = {32'b0, vd[31:0]};
            default: elem = vd;
        endcase

        data = '0;
        be   = '0;
        if (keep) begin
            data = VLEN'(elem) << off;
            be   = NBYTES'(elem_be(vsew)) << off[16:3];
        end
    end

endmodule

// File: rtl/rvv_vd_writeback.sv
// Collects per-lane ALU results for one vector instruction into a VLEN-wide
// destination image, then issues a single byte-enabled register-file write.
module rvv_vd_writeback
    import rvv_vd_writeback_pkg::*;
#(
    parameter int VLEN     = 128,
    parameter int NB_LANES = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [4:0]                  vd_addr,
    input  logic [2:0]                  vsew,
    input  logic [10:0]                 vl,
    input  logic                        mask_en,
    input  logic [VLEN-1:0]             v0,
    input  logic [64*(1<<NB_LANES)-1:0] lane_vd,
    input  logic [10*(1<<NB_LANES)-1:0] lane_idx,
    input  logic [(1<<NB_LANES)-1:0]    lane_vld,
    input  logic                        alu_done,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [4:0]                  wr_addr,
    output logic [VLEN-1:0]             wr_data,
    output logic [VLEN/8-1:0]           wr_be,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int LANES  = 1 << NB_LANES;
    localparam int NBYTES = VLEN / 8;

    logic [1:0]        state;
    logic [2:0]        vsew_q;
    logic [10:0]       vl_q;
    logic              mask_q;
    logic [VLEN-1:0]   v0_q;
    logic [VLEN-1:0]   data_q;
    logic [NBYTES-1:0] be_q;
    logic [4:0]        addr_q;
    logic              done_q;
    logic              err_q;

    logic [VLEN-1:0]   ins_data [LANES];
    logic [NBYTES-1:0] ins_be   [LANES];
    logic [VLEN-1:0]   merge_data;
    logic [NBYTES-1:0] merge_be;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        rvv_elem_insert #(.VLEN(VLEN)) u_insert (
            .vsew    (vsew_q),
            .idx     (lane_idx[10*g +: 10]),
            .vl      (vl_q),
            .mask_en (mask_q),
            .v0      (v0_q),
            .vd      (lane_vd[64*g +: 64]),
            .vld     (lane_vld[g]),
            .data    (ins_data[g]),
            .be      (ins_be[g])
        );
    end

    // Ascending lane order lets the highest-numbered lane win on equal indices.
    always_comb begin
        merge_data = data_q;
        merge_be   = be_q;
        for (int l = 0; l < LANES; l++) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (ins_be[l][b]) merge_data[8*b +: 8] = ins_data[l][8*b +: 8];
            end
            merge_be = merge_be | ins_be[l];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            vsew_q <= SEW_8;
            vl_q   <= '0;
            mask_q <= 1'b0;
            v0_q   <= '0;
            data_q <= '0;
            be_q   <= '0;
            addr_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (vsew <= SEW_64) begin
                            vsew_q <= vsew;
                            vl_q   <= vl;
                            mask_q <= mask_en;
                            v0_q   <= v0;
                            addr_q <= vd_addr;
                            data_q <= '0;
                            be_q   <= '0;
                            state  <= ST_COLLECT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    data_q <= merge_data;
                    be_q   <= merge_be;
                    if (alu_done) state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (wr_ready) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wr_valid = (state == ST_WRITE);
    assign busy     = (state != ST_IDLE);
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign wr_be    = be_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_rvv_vd_writeback.sv
// Directed bench for rvv_vd_writeback with two lanes and VLEN=128.
module tb_rvv_vd_writeback;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [4:0]   vd_addr;
    logic [2:0]   vsew;
    logic [10:0]  vl;
    logic         mask_en;
    logic [127:0] v0;
    logic [127:0] lane_vd;
    logic [19:0]  lane_idx;
    logic [1:0]   lane_vld;
    logic         alu_done;
    logic         wr_valid;
    logic         wr_ready;
    logic [4:0]   wr_addr;
    logic [127:0] wr_data;
    logic [15:0]  wr_be;
    logic         busy;
    logic         done;
    logic         err;

    int vectors = 0;
    int miscompares = 0;

    rvv_vd_writeback #(.VLEN(128), .NB_LANES(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .vd_addr  (vd_addr),
        .vsew     (vsew),
        .vl       (vl),
        .mask_en  (mask_en),
        .v0       (v0),
        .lane_vd  (lane_vd),
        .lane_idx (lane_idx),
        .lane_vld (lane_vld),
        .alu_done (alu_done),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_lanes(input logic v0l, input logic [9:0] i0, input logic [63:0] d0,
                             input logic v1l, input logic [9:0] i1, input logic [63:0] d1);
        lane_vld = {v1l, v0l};
        lane_idx = {i1, i0};
        lane_vd  = {d1, d0};
    endtask

    task automatic begin_instr(input logic [4:0] a, input logic [2:0] s, input logic [10:0] n,
                               input logic m, input logic [127:0] mv);
        start = 1'b1; vd_addr = a; vsew = s; vl = n; mask_en = m; v0 = mv;
        tick();
        start = 1'b0; vsew = 3'd0; mask_en = 1'b0; v0 = '0;
    endtask

    // Delivers idx 0..15 over eight cycles, value = base + idx, alu_done on the last.
    task automatic stream16(input logic [7:0] base);
        for (int c = 0; c < 8; c++) begin
            set_lanes(1'b1, 10'(2*c), 64'(base + 8'(2*c)), 1'b1, 10'(2*c+1), 64'(base + 8'(2*c+1)));
            alu_done = (c == 7);
            tick();
        end
        set_lanes(1'b0, 10'd0, 64'd0, 1'b0, 10'd0, 64'd0);
        alu_done = 1'b0;
    endtask

    task automatic handshake();
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        chk("done_pulse", 128'(done), 128'd1);
        chk("idle_busy", 128'(busy), 128'd0);
        tick();
        chk("done_one_cycle", 128'(done), 128'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; vd_addr = '0; vsew = '0; vl = '0; mask_en = 1'b0;
        v0 = '0; lane_vd = '0; lane_idx = '0; lane_vld = '0; alu_done = 1'b0; wr_ready = 1'b0;
        tick();
        // reset wins over a simultaneous start
        start = 1'b1; vl = 11'd16;
        tick();
        reset = 1'b0; start = 1'b0;
        tick();
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_wr_valid", 128'(wr_valid), 128'd0);
        chk("rst_done_err", 128'({done, err}), 128'd0);
        chk("rst_wr_be", 128'(wr_be), 128'd0);
        chk("rst_wr_data", wr_data, 128'd0);
        chk("rst_wr_addr", 128'(wr_addr), 128'd0);

        // SEW=8 full register, two lanes ascending
        begin_instr(5'd5, 3'd0, 11'd16, 1'b0, '0);
        chk("collect_busy", 128'(busy), 128'd1);
        stream16(8'h00);
        chk("full_wr_valid", 128'(wr_valid), 128'd1);
        chk("full_wr_addr", 128'(wr_addr), 128'd5);
        chk("full_wr_data", wr_data, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("full_wr_be", 128'(wr_be), 128'hFFFF);
        handshake();

        // SEW=32 with vl=3: idx3 is tail, upper bits of lane_vd are discarded
        begin_instr(5'd7, 3'd2, 11'd3, 1'b0, '0);
        set_lanes(1'b1, 10'd0, 64'hDEAD0000_11111111, 1'b1, 10'd1, 64'h22222222);
        tick();
        set_lanes(1'b1, 10'd2, 64'h33333333, 1'b1, 10'd3, 64'h44444444);
        alu_done = 1'b1;
        tick();
        set_lanes(1'b0, 10'd0, 64'd0, 1'b0, 10'd0, 64'd0);
        alu_done = 1'b0;
        chk("vl3_wr_be", 128'(wr_be), 128'h0FFF);
        chk("vl3_wr_data", wr_data, 128'h00000000_33333333_22222222_11111111);
        handshake();

        // SEW=8 masked by v0=0x5555
        begin_instr(5'd9, 3'd0, 11'd16, 1'b1, 128'h5555);
        stream16(8'h80);
        chk("mask_wr_be", 128'(wr_be), 128'h5555);
        chk("mask_wr_data", wr_data, 128'h008E008C008A00880086008400820080);
        handshake();

        // same-cycle collision after an earlier write to the same index; start while busy ignored
        begin_instr(5'd1, 3'd0, 11'd16, 1'b0, '0);
        set_lanes(1'b1, 10'd2, 64'h11, 1'b0, 10'd0, 64'd0);
        start = 1'b1; vsew = 3'd5;
        tick();
        start = 1'b0; vsew = 3'd0;
        chk("busy_start_no_err", 128'(err), 128'd0);
        set_lanes(1'b1, 10'd2, 64'hAA, 1'b1, 10'd2, 64'hBB);
        alu_done = 1'b1;
        tick();
        set_lanes(1'b0, 10'd0, 64'd0, 1'b0, 10'd0, 64'd0);
        alu_done = 1'b0;
        chk("collide_wr_data", wr_data, 128'h00BB0000);
        chk("collide_wr_be", 128'(wr_be), 128'h0004);
        handshake();

        // SEW=64: idx2 lands past VLEN and is dropped
        begin_instr(5'd3, 3'd3, 11'd4, 1'b0, '0);
        set_lanes(1'b1, 10'd1, 64'h0123456789ABCDEF, 1'b1, 10'd2, 64'hFFFFFFFFFFFFFFFF);
        alu_done = 1'b1;
        tick();
        set_lanes(1'b0, 10'd0, 64'd0, 1'b0, 10'd0, 64'd0);
        alu_done = 1'b0;
        chk("sew64_wr_data", wr_data, {64'h0123456789ABCDEF, 64'h0});
        chk("sew64_wr_be", 128'(wr_be), 128'hFF00);
        handshake();

        // WRITE stall with lane traffic ignored, then reset on the third stall cycle
        begin_instr(5'd12, 3'd0, 11'd16, 1'b0, '0);
        set_lanes(1'b1, 10'd0, 64'h5A, 1'b0, 10'd0, 64'd0);
        alu_done = 1'b1;
        tick();
        set_lanes(1'b1, 10'd1, 64'h77, 1'b0, 10'd0, 64'd0);
        alu_done = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("stall_wr_valid", 128'(wr_valid), 128'd1);
            chk("stall_wr_data", wr_data, 128'h5A);
            chk("stall_wr_be", 128'(wr_be), 128'h0001);
            chk("stall_wr_addr", 128'(wr_addr), 128'd12);
            tick();
        end
        set_lanes(1'b0, 10'd0, 64'd0, 1'b0, 10'd0, 64'd0);
        alu_done = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("stallrst_wr_valid", 128'(wr_valid), 128'd0);
        chk("stallrst_busy", 128'(busy), 128'd0);
        chk("stallrst_done", 128'(done), 128'd0);
        chk("stallrst_payload", {wr_data[111:0], wr_be}, 128'd0);
        chk("stallrst_wr_addr", 128'(wr_addr), 128'd0);
        tick();
        chk("stallrst_no_done", 128'(done), 128'd0);

        // illegal SEW
        start = 1'b1; vsew = 3'd5; vl = 11'd4;
        tick();
        start = 1'b0; vsew = 3'd0;
        chk("bad_sew_err", 128'(err), 128'd1);
        chk("bad_sew_busy", 128'(busy), 128'd0);
        tick();
        chk("bad_sew_err_pulse", 128'(err), 128'd0);
        chk("bad_sew_still_idle", 128'(busy), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
